// File: rtl/rv32i_decode_queue.sv
// Buffered RV32I decode front-end: a DEPTH-entry fetch FIFO feeding a registered
// control bundle on a valid/ready interface, with single-cycle flush.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module rv32i_decode_queue #(
    parameter int unsigned  DEPTH     = 4,
    parameter bit           ENABLE_MD = 1'b1,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [`ALU_OP_WIDTH-1:0] out_alu_op,
    output logic [31:0]              out_imm,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic                     out_uses_rs1,
    output logic                     out_uses_rs2,
    output logic                     out_wr_reg,
    output logic                     out_dmem_en,
    output logic                     out_dmem_wen,
    output logic                     out_branch,
    output logic                     out_jal,
    output logic                     out_jalr,
    output logic                     out_system,
    output logic                     out_uses_md,
    output logic                     out_illegal,
    output logic [PTR_W:0]           count
);

    typedef logic [`ALU_OP_WIDTH-1:0] alu_t;
    localparam alu_t ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3;
    localparam alu_t ALU_SLTU = 4'd4,  ALU_XOR = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7;
    localparam alu_t ALU_OR   = 4'd8,  ALU_AND = 4'd9,  ALU_SEQ  = 4'd10, ALU_SNE  = 4'd11;
    localparam alu_t ALU_SGE  = 4'd12, ALU_SGEU = 4'd13;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (count != '0) && (!out_valid || out_ready) && !flush;

    // Decode of the FIFO head
    logic [31:0] head_inst, head_pc;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign opcode    = head_inst[6:0];
    assign f3        = head_inst[14:12];
    assign f7        = head_inst[31:25];
    assign rd        = head_inst[11:7];
    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                    head_inst[11:8], 1'b0};
    assign imm_u = {head_inst[31:12], 12'b0};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                    head_inst[30:21], 1'b0};

    function automatic alu_t alu_of(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    alu_t        d_alu;
    logic [31:0] d_imm;
    logic d_u1, d_u2, d_wr, d_men, d_mwen, d_br, d_jal, d_jalr, d_sys, d_md, d_ill;

    always_comb begin
        d_alu = ALU_ADD; d_imm = '0; d_u1 = 1'b0; d_u2 = 1'b0; d_wr = 1'b0;
        d_men = 1'b0; d_mwen = 1'b0; d_br = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
        d_sys = 1'b0; d_md = 1'b0; d_ill = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                d_imm = imm_i; d_u1 = 1'b1; d_wr = 1'b1; d_men = 1'b1;
                d_ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d_imm = imm_s; d_u1 = 1'b1; d_u2 = 1'b1; d_men = 1'b1; d_mwen = 1'b1;
                d_ill = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                d_imm = imm_b; d_u1 = 1'b1; d_u2 = 1'b1; d_br = 1'b1;
                case (f3)
                    3'b000:  d_alu = ALU_SEQ;
                    3'b001:  d_alu = ALU_SNE;
                    3'b100:  d_alu = ALU_SLT;
                    3'b101:  d_alu = ALU_SGE;
                    3'b110:  d_alu = ALU_SLTU;
                    3'b111:  d_alu = ALU_SGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_imm = imm_j; d_wr = 1'b1; d_jal = 1'b1;
            end
            OPC_JALR: begin
                d_imm = imm_i; d_u1 = 1'b1; d_wr = 1'b1; d_jalr = 1'b1;
                d_ill = (f3 != 3'b000);
            end
            OPC_MISC_MEM: d_imm = imm_i;
            OPC_OP_IMM: begin
                // Only the right shift uses funct7[5]; ADDI with a negative imm must stay ADD
                d_imm = imm_i; d_u1 = 1'b1; d_wr = 1'b1;
                d_alu = alu_of(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001) d_ill = (f7 != 7'b0000000);
                if (f3 == 3'b101) d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                d_u1 = 1'b1; d_u2 = 1'b1; d_wr = 1'b1;
                if (f7 == 7'b0000000) begin
                    d_alu = alu_of(f3, 1'b0);
                end else if (f7 == 7'b0100000) begin
                    d_alu = alu_of(f3, 1'b1);
                    d_ill = (f3 != 3'b000) && (f3 != 3'b101);
                end else if (f7 == 7'b0000001 && ENABLE_MD) begin
                    d_md = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                d_imm = imm_i; d_sys = 1'b1; d_wr = (f3 != 3'b000);
                d_u1 = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
                d_ill = (f3 == 3'b100);
            end
            OPC_AUIPC, OPC_LUI: begin
                d_imm = imm_u; d_wr = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        if (head_inst[1:0] != 2'b11) d_ill = 1'b1;
        d_wr   = d_wr && (rd != 5'd0) && !d_ill;
        d_men  = d_men && !d_ill;
        d_mwen = d_mwen && !d_ill;
        d_br   = d_br && !d_ill;
        d_jal  = d_jal && !d_ill;
        d_jalr = d_jalr && !d_ill;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; out_valid <= 1'b0;
            out_inst <= '0; out_pc <= '0; out_alu_op <= '0; out_imm <= '0;
            out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0;
            out_uses_rs1 <= 1'b0; out_uses_rs2 <= 1'b0; out_wr_reg <= 1'b0;
            out_dmem_en <= 1'b0; out_dmem_wen <= 1'b0; out_branch <= 1'b0;
            out_jal <= 1'b0; out_jalr <= 1'b0; out_system <= 1'b0;
            out_uses_md <= 1'b0; out_illegal <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                out_valid <= 1'b1;
                out_inst <= head_inst; out_pc <= head_pc; out_alu_op <= d_alu;
                out_imm <= d_imm; out_rs1 <= head_inst[19:15]; out_rs2 <= head_inst[24:20];
                out_rd <= rd; out_uses_rs1 <= d_u1; out_uses_rs2 <= d_u2; out_wr_reg <= d_wr;
                out_dmem_en <= d_men; out_dmem_wen <= d_mwen; out_branch <= d_br;
                out_jal <= d_jal; out_jalr <= d_jalr; out_system <= d_sys;
                out_uses_md <= d_md; out_illegal <= d_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Directed bench for rv32i_decode_queue (DEPTH=4, ENABLE_MD=0): decode vector table plus
// backpressure, flush, throughput and mid-run reset sequences.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_rv32i_decode_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm;
    logic [`ALU_OP_WIDTH-1:0] out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic out_uses_rs1, out_uses_rs2, out_wr_reg, out_dmem_en, out_dmem_wen;
    logic out_branch, out_jal, out_jalr, out_system, out_uses_md, out_illegal;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    rv32i_decode_queue #(.DEPTH(4), .ENABLE_MD(1'b0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2), .out_wr_reg(out_wr_reg),
        .out_dmem_en(out_dmem_en), .out_dmem_wen(out_dmem_wen), .out_branch(out_branch),
        .out_jal(out_jal), .out_jalr(out_jalr), .out_system(out_system),
        .out_uses_md(out_uses_md), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_SEQ = 4'd10;

    typedef struct {
        logic [31:0] inst, pc;
        logic        full;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic u1, u2, wr, men, mwen, br, jal, jalr, sys, ill;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // inst, pc, full, alu, imm, rs1, rs2, rd, u1 u2 wr men mwen br jal jalr sys ill
        vecs[0]  = '{32'h00500093, 32'h100, 1, A_ADD, 32'd5,        0, 5, 1,   1,1'b0,1,0,0,0,0,0,0,0};
        vecs[1]  = '{32'hFE208CE3, 32'h104, 1, A_SEQ, 32'hFFFFFFF8, 1, 2, 25,  1,1,0,0,0,1,0,0,0,0};
        vecs[2]  = '{32'h00000000, 32'h108, 0, A_ADD, 32'd0,        0, 0, 0,   0,0,0,0,0,0,0,0,0,1};
        vecs[3]  = '{32'h022081B3, 32'h10C, 0, A_ADD, 32'd0,        1, 2, 3,   0,0,0,0,0,0,0,0,0,1};
        vecs[4]  = '{32'h00812283, 32'h110, 1, A_ADD, 32'd8,        2, 8, 5,   1,0,1,1,0,0,0,0,0,0};
        vecs[5]  = '{32'hFE612E23, 32'h114, 1, A_ADD, 32'hFFFFFFFC, 2, 6, 28,  1,1,0,1,1,0,0,0,0,0};
        vecs[6]  = '{32'h010000EF, 32'h118, 1, A_ADD, 32'd16,       0, 16, 1,  0,0,1,0,0,0,1,0,0,0};
        vecs[7]  = '{32'h123451B7, 32'h11C, 1, A_ADD, 32'h12345000, 8, 3, 3,   0,0,1,0,0,0,0,0,0,0};
        vecs[8]  = '{32'h402083B3, 32'h120, 1, A_SUB, 32'd0,        1, 2, 7,   1,1,1,0,0,0,0,0,0,0};
        vecs[9]  = '{32'h00000013, 32'h124, 1, A_ADD, 32'd0,        0, 0, 0,   1,0,0,0,0,0,0,0,0,0};
        vecs[10] = '{32'h40109093, 32'h128, 0, A_ADD, 32'd0,        1, 1, 1,   0,0,0,0,0,0,0,0,0,1};
        vecs[11] = '{32'h4030D113, 32'h12C, 1, A_SRA, 32'h403,      1, 3, 2,   1,0,1,0,0,0,0,0,0,0};
        vecs[12] = '{32'hFE20ACE3, 32'h130, 0, A_ADD, 32'd0,        1, 2, 25,  0,0,0,0,0,0,0,0,0,1};
        vecs[13] = '{32'h004280E7, 32'h134, 1, A_ADD, 32'd4,        5, 4, 1,   1,0,1,0,0,0,0,1,0,0};
        vecs[14] = '{32'h00004501, 32'h138, 0, A_ADD, 32'd0,        0, 0, 10,  0,0,0,0,0,0,0,0,0,1};
        vecs[15] = '{32'h00000073, 32'h13C, 0, A_ADD, 32'd0,        0, 0, 0,   0,0,0,0,0,0,0,0,1,0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        repeat (3) tick();
        check("reset_state", {count, out_valid, out_inst, out_imm, out_wr_reg},
              {3'd0, 1'b0, 32'd0, 32'd0, 1'b0});
        reset = 1'b0;
        tick();
        check("reset_in_ready", {125'd0, in_ready}, 128'd1);

        // Decode table: one entry at a time, checking the one-edge latency then the bundle
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
            tick();
            in_valid = 1'b0;
            check($sformatf("latency%0d", i), {126'd0, out_valid, count == 3'd1}, 128'b01);
            tick();
            check($sformatf("vec%0d", i),
                  {out_valid, out_inst, out_pc, vecs[i].full ? out_alu_op : 4'd0,
                   vecs[i].full ? out_imm : 32'd0, out_rs1, out_rs2, out_rd,
                   vecs[i].full & out_uses_rs1, vecs[i].full & out_uses_rs2, out_wr_reg,
                   out_dmem_en, out_dmem_wen, out_branch, out_jal, out_jalr, out_system,
                   out_illegal},
                  {1'b1, vecs[i].inst, vecs[i].pc, vecs[i].full ? vecs[i].alu : 4'd0,
                   vecs[i].full ? vecs[i].imm : 32'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].full & vecs[i].u1, vecs[i].full & vecs[i].u2, vecs[i].wr,
                   vecs[i].men, vecs[i].mwen, vecs[i].br, vecs[i].jal, vecs[i].jalr,
                   vecs[i].sys, vecs[i].ill});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("uses_md_off", {127'd0, out_uses_md}, 128'd0);

        // Backpressure: offer 6 with out_ready low; 4 queued + 1 held = 5 accepted
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_inst = {12'(k), 20'h00013}; in_pc = 32'h200 + 32'(4 * k);
            tick();
        end
        in_valid = 1'b0;
        check("full_state", {count, in_ready, out_valid, out_pc}, {3'd4, 1'b0, 1'b1, 32'h200});
        tick();
        check("held_stable", {out_valid, out_pc, out_imm}, {1'b1, 32'h200, 32'd0});
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d", k), {out_valid, out_pc, out_imm},
                  {1'b1, 32'h200 + 32'(4 * k), 32'(k)});
            tick();
        end
        check("drain_empty", {out_valid, count, in_ready}, {1'b0, 3'd0, 1'b1});
        out_ready = 1'b0;

        // Flush with count=3, out_valid=1 and a same-cycle offer
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300 + 32'(4 * k);
            tick();
        end
        check("pre_flush", {count, out_valid}, {3'd3, 1'b1});
        flush = 1'b1; in_pc = 32'h3F0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("post_flush", {count, out_valid, in_ready}, {3'd0, 1'b0, 1'b1});
        tick();
        tick();
        check("flush_dropped", {count, out_valid}, {3'd0, 1'b0});
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h5A0;
        tick();
        in_valid = 1'b0;
        tick();
        check("after_flush", {out_valid, out_pc, out_imm}, {1'b1, 32'h5A0, 32'd5});
        out_ready = 1'b1;
        tick();

        // Streaming: one per cycle, pointers wrap twice
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                in_valid = 1'b1; in_inst = {12'(c), 20'h00013}; in_pc = 32'h400 + 32'(4 * c);
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 2)
                check($sformatf("stream%0d", c), {out_valid, out_pc, out_imm},
                      {1'b1, 32'h400 + 32'(4 * (c - 2)), 32'(c - 2)});
            check($sformatf("stream_cnt%0d", c), {125'd0, count},
                  {125'd0, (c >= 1 && c <= 10) ? 3'd1 : 3'd0});
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stream_done", {out_valid, count}, {1'b0, 3'd0});

        // Reset mid-operation drops queued work
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h600 + 32'(4 * k);
            tick();
        end
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset", {count, out_valid, in_ready, out_pc}, {3'd0, 1'b0, 1'b1, 32'd0});
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h700;
        tick();
        in_valid = 1'b0;
        tick();
        check("after_reset", {out_valid, out_pc, count}, {1'b1, 32'h700, 3'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
